// File: rtl/sci_uart_peer_pkg.sv
// SCI asynchronous-mode frame definitions shared by the UART peer TX and RX paths.
package sci_uart_peer_pkg;
  typedef struct packed {
    logic chr;
    logic pe;
    logic oe;
    logic stop;
  } SCI_FRAME_CFG_t;

  localparam logic SCI_IDLE_LEVEL = 1'b1;
  localparam int   SCI_DIV_MIN    = 2;

  typedef enum logic [2:0] {
    SCI_RX_IDLE,
    SCI_RX_START,
    SCI_RX_DATA,
    SCI_RX_PARITY,
    SCI_RX_STOP,
    SCI_RX_WAIT_HIGH
  } SCI_RX_STATE_t;

  // Wire order, bit 0 first; positions past the frame sit at idle so stop bits come for free.
  function automatic logic [11:0] sci_frame_bits(input logic [7:0] data, input SCI_FRAME_CFG_t cfg);
    logic [7:0]  d;
    logic [11:0] f;
    d    = cfg.chr ? {1'b0, data[6:0]} : data;
    f    = {12{SCI_IDLE_LEVEL}};
    f[0] = ~SCI_IDLE_LEVEL;
    for (int i = 0; i < 8; i++)
      if (!(cfg.chr && i == 7)) f[i+1] = d[i];
    if (cfg.pe) f[cfg.chr ? 8 : 9] = (^d) ^ cfg.oe;
    return f;
  endfunction

  function automatic logic [3:0] sci_frame_len(input SCI_FRAME_CFG_t cfg);
    return 4'd10 - {3'b0, cfg.chr} + {3'b0, cfg.pe} + {3'b0, cfg.stop};
  endfunction
endpackage

// File: rtl/sci_uart_peer_rx.sv
// Receiver: 2-flop synchronizer, mid-bit sampling FSM and sticky error flags.
module sci_uart_peer_rx
  import sci_uart_peer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             chr,
  input  logic             pe,
  input  logic             oe,
  input  logic [DIV_W-1:0] div,
  input  logic             rxd,
  input  logic             ack,
  output logic [7:0]       data,
  output logic             valid,
  output logic             per,
  output logic             fer,
  output logic             ovr
);
  SCI_RX_STATE_t    st;
  logic [1:0]       sync;
  logic             rxs, rxs_d;
  logic [DIV_W-1:0] cnt, d;
  logic [2:0]       bitn;
  logic [7:0]       sh, rx_byte;
  logic             c_chr, c_pe, c_oe, pbad;
  logic             tick, mid, done;

  assign rxs     = sync[1];
  assign tick    = (cnt == d - 1'b1);
  assign mid     = (cnt == (d >> 1) - 1'b1);
  assign rx_byte = c_chr ? {1'b0, sh[7:1]} : sh;
  assign done    = (st == SCI_RX_STOP) && tick;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync  <= {2{SCI_IDLE_LEVEL}};
      rxs_d <= SCI_IDLE_LEVEL;
      st    <= SCI_RX_IDLE;
      cnt   <= '0;
      d     <= DIV_W'(SCI_DIV_MIN);
      bitn  <= '0;
      sh    <= '0;
      c_chr <= 1'b0;
      c_pe  <= 1'b0;
      c_oe  <= 1'b0;
      pbad  <= 1'b0;
    end else if (CE) begin
      sync  <= {sync[0], rxd};
      rxs_d <= rxs;
      cnt   <= cnt + 1'b1;
      case (st)
        SCI_RX_IDLE:
          if (rxs_d && !rxs) begin
            st    <= SCI_RX_START;
            cnt   <= '0;
            d     <= div;
            c_chr <= chr;
            c_pe  <= pe;
            c_oe  <= oe;
            pbad  <= 1'b0;
            bitn  <= '0;
          end
        SCI_RX_START:
          if (mid) begin
            cnt <= '0;
            st  <= rxs ? SCI_RX_IDLE : SCI_RX_DATA;
          end
        SCI_RX_DATA:
          if (tick) begin
            cnt  <= '0;
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == (c_chr ? 3'd6 : 3'd7)) st <= c_pe ? SCI_RX_PARITY : SCI_RX_STOP;
          end
        SCI_RX_PARITY:
          if (tick) begin
            cnt  <= '0;
            pbad <= rxs ^ (^rx_byte) ^ c_oe;
            st   <= SCI_RX_STOP;
          end
        SCI_RX_STOP:
          if (tick) begin
            cnt <= '0;
            st  <= rxs ? SCI_RX_IDLE : SCI_RX_WAIT_HIGH;
          end
        SCI_RX_WAIT_HIGH:
          if (rxs) st <= SCI_RX_IDLE;
        default: st <= SCI_RX_IDLE;
      endcase
    end
  end

  // A completing frame beats a simultaneous ack, so the fresh byte is never lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data  <= '0;
      valid <= 1'b0;
      per   <= 1'b0;
      fer   <= 1'b0;
      ovr   <= 1'b0;
    end else if (CE) begin
      if (done && (!valid || ack)) begin
        data  <= rx_byte;
        valid <= 1'b1;
        per   <= pbad;
        fer   <= ~rxs;
        ovr   <= 1'b0;
      end else if (done) begin
        ovr <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
        per   <= 1'b0;
        fer   <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sci_uart_peer.sv
// Host-side SCI UART peer: holding register + shifter TX, instantiated RX.
module sci_uart_peer
  import sci_uart_peer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CFG_CHR,
  input  logic             CFG_PE,
  input  logic             CFG_OE,
  input  logic             CFG_STOP,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             SER_RXD,
  output logic             SER_TXD,
  input  logic [7:0]       TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic             TX_BUSY,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  input  logic             RX_ACK,
  output logic             RX_PER,
  output logic             RX_FER,
  output logic             RX_OVR
);
  SCI_FRAME_CFG_t   cfg;
  logic [DIV_W-1:0] div_eff, tx_div, tx_cnt;
  logic             hold_full;
  logic [7:0]       hold_data;
  logic [11:0]      tx_sh;
  logic [3:0]       tx_len, tx_bit;
  logic             tx_busy, tx_end, tx_load;

  assign cfg     = '{chr: CFG_CHR, pe: CFG_PE, oe: CFG_OE, stop: CFG_STOP};
  assign div_eff = (CFG_DIV < DIV_W'(SCI_DIV_MIN)) ? DIV_W'(SCI_DIV_MIN) : CFG_DIV;
  assign tx_end  = tx_busy && (tx_cnt == tx_div - 1'b1) && (tx_bit == tx_len - 1'b1);
  // Reloading on the last stop tick gives back-to-back frames with no idle bit.
  assign tx_load = hold_full && (!tx_busy || tx_end);

  assign SER_TXD  = tx_sh[0];
  assign TX_READY = ~hold_full;
  assign TX_BUSY  = tx_busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (CE) begin
      if (tx_load) begin
        hold_full <= 1'b0;
      end else if (TX_VALID && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= TX_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_sh   <= {12{SCI_IDLE_LEVEL}};
      tx_len  <= '0;
      tx_bit  <= '0;
      tx_div  <= DIV_W'(SCI_DIV_MIN);
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
    end else if (CE) begin
      if (tx_load) begin
        tx_sh   <= sci_frame_bits(hold_data, cfg);
        tx_len  <= sci_frame_len(cfg);
        tx_div  <= div_eff;
        tx_cnt  <= '0;
        tx_bit  <= '0;
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == tx_div - 1'b1) begin
          tx_cnt <= '0;
          tx_sh  <= {SCI_IDLE_LEVEL, tx_sh[11:1]};
          if (tx_end) tx_busy <= 1'b0;
          else        tx_bit  <= tx_bit + 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  sci_uart_peer_rx #(.DIV_W(DIV_W)) u_rx (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .chr   (CFG_CHR),
    .pe    (CFG_PE),
    .oe    (CFG_OE),
    .div   (div_eff),
    .rxd   (SER_RXD),
    .ack   (RX_ACK),
    .data  (RX_DATA),
    .valid (RX_VALID),
    .per   (RX_PER),
    .fer   (RX_FER),
    .ovr   (RX_OVR)
  );
endmodule

// File: tb/tb_sci_uart_peer.sv
// Scoreboarded bench for sci_uart_peer: TX waveform capture, loopback and injected RX frames.
module tb_sci_uart_peer;
  logic        CLK = 1'b0, RST_N = 1'b0, CE = 1'b1;
  logic        CFG_CHR = 1'b0, CFG_PE = 1'b0, CFG_OE = 1'b0, CFG_STOP = 1'b0;
  logic [15:0] CFG_DIV = 16'd16;
  logic        SER_RXD, SER_TXD;
  logic [7:0]  TX_DATA = 8'h00;
  logic        TX_VALID = 1'b0, TX_READY, TX_BUSY;
  logic [7:0]  RX_DATA;
  logic        RX_VALID, RX_ACK = 1'b0, RX_PER, RX_FER, RX_OVR;
  logic        loop = 1'b0, inj = 1'b1;
  int          n_chk = 0, n_pass = 0;

  typedef struct packed { logic [7:0] data; logic per; logic fer; } rx_exp_t;
  rx_exp_t     rx_q[$];
  logic [11:0] tx_q[$];

  assign SER_RXD = loop ? SER_TXD : inj;
  always #5 CLK = ~CLK;

  sci_uart_peer #(.DIV_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE),
    .CFG_CHR(CFG_CHR), .CFG_PE(CFG_PE), .CFG_OE(CFG_OE), .CFG_STOP(CFG_STOP), .CFG_DIV(CFG_DIV),
    .SER_RXD(SER_RXD), .SER_TXD(SER_TXD),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_BUSY(TX_BUSY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ACK(RX_ACK),
    .RX_PER(RX_PER), .RX_FER(RX_FER), .RX_OVR(RX_OVR)
  );

  task automatic cfg_set(input logic chr, input logic pe, input logic oe, input logic stop, input logic [15:0] div);
    CFG_CHR = chr; CFG_PE = pe; CFG_OE = oe; CFG_STOP = stop; CFG_DIV = div;
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ok);
    int n = 0;
    while (TX_READY !== 1'b1 && n < 3000) begin @(negedge CLK); n++; end
    ok = (TX_READY === 1'b1);
    TX_DATA = d; TX_VALID = ok;
    @(negedge CLK);
    TX_VALID = 1'b0;
  endtask

  // Observes only: first sample of each bit period, and whether the level held for all of it.
  task automatic capture_frame(input int div, input int nbits, output logic [11:0] bits, output bit held, output int lat);
    lat = 0; bits = '1; held = 1'b1;
    while (SER_TXD !== 1'b0 && lat < 5000) begin @(negedge CLK); lat++; end
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < div; c++) begin
        if (c == 0) bits[i] = SER_TXD;
        else if (SER_TXD !== bits[i]) held = 1'b0;
        @(negedge CLK);
      end
  endtask

  task automatic inject_frame(input logic [11:0] bits, input int nbits, input int div);
    for (int i = 0; i < nbits; i++) begin inj = bits[i]; repeat (div) @(negedge CLK); end
  endtask

  task automatic wait_rx(output bit ok);
    int n = 0;
    while (RX_VALID !== 1'b1 && n < 3000) begin @(negedge CLK); n++; end
    ok = (RX_VALID === 1'b1);
  endtask

  task automatic ack_rx;
    RX_ACK = 1'b1; @(negedge CLK); RX_ACK = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({SER_TXD, TX_READY, TX_BUSY, RX_VALID, RX_PER, RX_FER, RX_OVR} !== 7'b1100000)
      $display("FAIL reset_flags: got %b want 1100000", {SER_TXD, TX_READY, TX_BUSY, RX_VALID, RX_PER, RX_FER, RX_OVR});
    else n_pass++;
    n_chk++;
    if (RX_DATA !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", RX_DATA); else n_pass++;
  endtask

  task automatic test_8n1;
    bit ok, held, rok; logic [11:0] bits, exp; int lat; rx_exp_t e;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd16); loop = 1'b1;
    tx_q.push_back(12'h34A); rx_q.push_back({8'hA5, 1'b0, 1'b0});
    send_byte(8'hA5, ok);
    capture_frame(16, 10, bits, held, lat);
    exp = tx_q.pop_front();
    n_chk++; if (!ok) $display("FAIL 8n1_accept: TX_READY never high"); else n_pass++;
    n_chk++; if (bits[9:0] !== exp[9:0]) $display("FAIL 8n1_tx_bits: got %b want %b", bits[9:0], exp[9:0]); else n_pass++;
    n_chk++; if (!held) $display("FAIL 8n1_bit_hold: a bit changed inside its 16-cycle period"); else n_pass++;
    n_chk++; if (lat !== 1) $display("FAIL 8n1_tx_latency: got %0d want 1", lat); else n_pass++;
    n_chk++; if ({TX_BUSY, SER_TXD} !== 2'b01) $display("FAIL 8n1_tx_idle: busy,txd got %b want 01", {TX_BUSY, SER_TXD}); else n_pass++;
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER, RX_OVR} !== {e.data, e.per, e.fer, 1'b0})
      $display("FAIL 8n1_rx: valid=%b data=%h per=%b fer=%b ovr=%b want data=%h no errors", RX_VALID, RX_DATA, RX_PER, RX_FER, RX_OVR, e.data);
    else n_pass++;
    ack_rx;
    n_chk++; if (RX_VALID !== 1'b0) $display("FAIL 8n1_ack: RX_VALID got %b want 0", RX_VALID); else n_pass++;
  endtask

  task automatic test_7o2;
    bit ok, held, rok; logic [11:0] bits, exp; int lat; rx_exp_t e; logic [7:0] d;
    cfg_set(1'b1, 1'b1, 1'b1, 1'b1, 16'd4); loop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'h53 : 8'hD3;  // bit 7 must be ignored in 7-bit mode
      tx_q.push_back(12'h7A6); rx_q.push_back({8'h53, 1'b0, 1'b0});
      send_byte(d, ok);
      capture_frame(4, 11, bits, held, lat);
      exp = tx_q.pop_front();
      n_chk++;
      if (!ok || !held || bits[10:0] !== exp[10:0])
        $display("FAIL 7o2_tx_bits[%0d]: got %b held=%b want %b", k, bits[10:0], held, exp[10:0]);
      else n_pass++;
      wait_rx(rok); e = rx_q.pop_front();
      n_chk++;
      if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
        $display("FAIL 7o2_rx[%0d]: data=%h per=%b fer=%b want %h 0 0", k, RX_DATA, RX_PER, RX_FER, e.data);
      else n_pass++;
      ack_rx;
    end
  endtask

  task automatic test_div_min;
    bit ok, held, rok; logic [11:0] bits, exp; int lat; rx_exp_t e;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0); loop = 1'b1;
    tx_q.push_back(12'h34A); rx_q.push_back({8'hA5, 1'b0, 1'b0});
    send_byte(8'hA5, ok);
    capture_frame(2, 10, bits, held, lat);
    exp = tx_q.pop_front();
    n_chk++;
    if (!ok || !held || lat !== 1 || bits[9:0] !== exp[9:0])
      $display("FAIL div0_tx: got %b held=%b lat=%0d want %b held=1 lat=1", bits[9:0], held, lat, exp[9:0]);
    else n_pass++;
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
      $display("FAIL div0_rx: data=%h per=%b fer=%b want %h 0 0", RX_DATA, RX_PER, RX_FER, e.data);
    else n_pass++;
    ack_rx;
  endtask

  task automatic test_rx_errors;
    bit rok; rx_exp_t e;
    inj = 1'b1; loop = 1'b0;
    cfg_set(1'b0, 1'b1, 1'b0, 1'b0, 16'd16);
    repeat (5) @(negedge CLK);
    rx_q.push_back({8'h0F, 1'b1, 1'b0});
    inject_frame(12'h61E, 11, 16);  // 0x0F with wrong (odd) parity
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
      $display("FAIL 8e1_parity: data=%h per=%b fer=%b want %h %b %b", RX_DATA, RX_PER, RX_FER, e.data, e.per, e.fer);
    else n_pass++;
    ack_rx;
    rx_q.push_back({8'h55, 1'b0, 1'b1});
    inject_frame(12'h0AA, 11, 16);  // 0x55 with stop bit low; line then stays low
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
      $display("FAIL 8e1_framing: data=%h per=%b fer=%b want %h %b %b", RX_DATA, RX_PER, RX_FER, e.data, e.per, e.fer);
    else n_pass++;
    ack_rx;
    repeat (48) @(negedge CLK);
    n_chk++; if (RX_VALID !== 1'b0) $display("FAIL break_no_retrigger: RX_VALID got %b want 0", RX_VALID); else n_pass++;
    inj = 1'b1; repeat (20) @(negedge CLK);
    rx_q.push_back({8'h12, 1'b0, 1'b0});
    inject_frame(12'h424, 11, 16);
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
      $display("FAIL after_break_rx: data=%h per=%b fer=%b want %h 0 0", RX_DATA, RX_PER, RX_FER, e.data);
    else n_pass++;
    ack_rx;
  endtask

  task automatic test_overrun;
    bit ok1, ok2, rok; rx_exp_t e; int n = 0;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd8); loop = 1'b1;
    rx_q.push_back({8'h3C, 1'b0, 1'b0});
    send_byte(8'h3C, ok1);
    send_byte(8'hC3, ok2);
    wait_rx(rok);
    while (TX_BUSY !== 1'b0 && n < 3000) begin @(negedge CLK); n++; end
    repeat (10) @(negedge CLK);
    e = rx_q.pop_front();
    n_chk++;
    if (!ok1 || !ok2 || !rok || {RX_VALID, RX_DATA, RX_PER, RX_FER} !== {1'b1, e.data, e.per, e.fer})
      $display("FAIL overrun_data: valid=%b data=%h per=%b fer=%b want 1 %h 0 0", RX_VALID, RX_DATA, RX_PER, RX_FER, e.data);
    else n_pass++;
    n_chk++; if (RX_OVR !== 1'b1) $display("FAIL overrun_flag: RX_OVR got %b want 1", RX_OVR); else n_pass++;
    ack_rx;
    n_chk++;
    if ({RX_VALID, RX_PER, RX_FER, RX_OVR} !== 4'b0000)
      $display("FAIL overrun_ack: flags got %b want 0000", {RX_VALID, RX_PER, RX_FER, RX_OVR});
    else n_pass++;
  endtask

  task automatic test_glitch;
    bit rok; rx_exp_t e;
    inj = 1'b1; loop = 1'b0;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd16);
    repeat (5) @(negedge CLK);
    inj = 1'b0; repeat (4) @(negedge CLK); inj = 1'b1;
    repeat (40) @(negedge CLK);
    n_chk++; if (RX_VALID !== 1'b0) $display("FAIL glitch_false_start: RX_VALID got %b want 0", RX_VALID); else n_pass++;
    rx_q.push_back({8'h81, 1'b0, 1'b0});
    inject_frame(12'h302, 10, 16);
    wait_rx(rok); e = rx_q.pop_front();
    n_chk++;
    if (!rok || {RX_DATA, RX_PER, RX_FER} !== {e.data, e.per, e.fer})
      $display("FAIL glitch_recover_rx: data=%h per=%b fer=%b want %h 0 0", RX_DATA, RX_PER, RX_FER, e.data);
    else n_pass++;
    ack_rx;
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2, h1, h2; logic [11:0] b1, b2, exp; int l1, l2; logic gap_txd, gap_busy;
    inj = 1'b1; loop = 1'b0;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
    tx_q.push_back(12'h21E); tx_q.push_back(12'h3E0);
    send_byte(8'h0F, ok1);
    fork
      begin
        capture_frame(8, 10, b1, h1, l1);
        gap_txd = SER_TXD; gap_busy = TX_BUSY;
        capture_frame(8, 10, b2, h2, l2);
      end
      send_byte(8'hF0, ok2);
    join
    exp = tx_q.pop_front();
    n_chk++;
    if (!ok1 || !h1 || b1[9:0] !== exp[9:0]) $display("FAIL b2b_frame1: got %b held=%b want %b", b1[9:0], h1, exp[9:0]);
    else n_pass++;
    n_chk++;
    if ({gap_txd, gap_busy} !== 2'b01) $display("FAIL b2b_no_gap: txd,busy got %b want 01", {gap_txd, gap_busy});
    else n_pass++;
    exp = tx_q.pop_front();
    n_chk++;
    if (!ok2 || !h2 || l2 !== 0 || b2[9:0] !== exp[9:0])
      $display("FAIL b2b_frame2: got %b held=%b lat=%0d want %b lat=0", b2[9:0], h2, l2, exp[9:0]);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    bit ok; int n = 0;
    cfg_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd16); loop = 1'b1;
    send_byte(8'h00, ok);
    while (SER_TXD !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
    repeat (16 * 3 + 8) @(negedge CLK);
    n_chk++; if (!ok || SER_TXD !== 1'b0) $display("FAIL midframe_low: SER_TXD got %b want 0", SER_TXD); else n_pass++;
    #2 RST_N = 1'b0;
    #1;
    n_chk++; if (SER_TXD !== 1'b1) $display("FAIL async_reset_txd: SER_TXD got %b want 1", SER_TXD); else n_pass++;
    @(negedge CLK); RST_N = 1'b1; @(negedge CLK);
    n_chk++;
    if ({TX_READY, TX_BUSY, SER_TXD} !== 3'b101)
      $display("FAIL post_reset_tx: ready,busy,txd got %b want 101", {TX_READY, TX_BUSY, SER_TXD});
    else n_pass++;
    repeat (200) @(negedge CLK);
    n_chk++;
    if ({RX_VALID, SER_TXD} !== 2'b01) $display("FAIL post_reset_idle: valid,txd got %b want 01", {RX_VALID, SER_TXD});
    else n_pass++;
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset;
    RST_N = 1'b1;
    @(negedge CLK);
    test_8n1;
    test_7o2;
    test_div_min;
    test_rx_errors;
    test_overrun;
    test_glitch;
    test_back_to_back;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sci_uart_peer.md
# sci_uart_peer

Asynchronous-mode serial endpoint that sits on the far side of the SH on-chip SCI link: its receiver decodes frames driven on the CPU's TXD pin, and its transmitter drives frames onto the CPU's RXD pin. It is used as the host/debug-side UART and as the loopback partner in SCI system tests. The frame format matches the SCI asynchronous mode: 7/8 data bits LSB first, optional even/odd parity, 1/2 stop bits. It also provides a one-byte-deep byte interface in each direction.

## Interface
- DIV_W, 16: width of the bit-period divisor.
- Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable. All state advances only on CLK edges with CE=1.
- CFG_CHR  in  1  1 = 7 data bits, 0 = 8.
- CFG_PE  in  1  parity enable.
- CFG_OE  in  1  1 = odd parity, 0 = even.
- CFG_STOP  in  1  1 = two stop bits.
- CFG_DIV  in  DIV_W  bit period in CE cycles. Values 0 and 1 are treated as 2.
- SER_RXD  in  1  serial input, from CPU TXD. Asynchronous.
- SER_TXD  out  1  serial output, to CPU RXD. Idle high.
- TX_DATA  in  8  byte to send. In 7-bit mode bit 7 is ignored.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  holding register empty.
- TX_BUSY  out  1  shifter active (frame in progress).
- RX_DATA  out  8  last received byte. In 7-bit mode bit 7 = 0.
- RX_VALID  out  1  RX_DATA holds an unread byte.
- RX_ACK  in  1  consume RX_DATA and clear all error flags.
- RX_PER  out  1  parity error on the last accepted frame.
- RX_FER  out  1  framing error (first stop bit sampled low).
- RX_OVR  out  1  a frame completed while RX_VALID=1.

## Operation
- Configuration (CHR/PE/OE/STOP/DIV) is latched separately by TX and RX at each frame start. Changes made mid-frame take effect on the next frame.
- Frame: start(0), data bits LSB first, parity (if PE) = XOR(data) ^ OE, stop bits (1).
- TX:
  - A byte is accepted when CE & TX_VALID & TX_READY; it loads the holding register and TX_READY drops.
  - When the shifter is idle and the holding register is full, the shifter loads the byte on the next CE cycle. At that point TX_READY rises, TX_BUSY rises, and SER_TXD goes 0.
  - Each bit is driven for exactly DIV CE cycles.
  - After the last stop bit, the shifter either loads the holding register immediately (back-to-back, no idle gap) or goes idle with SER_TXD=1.
- RX:
  - SER_RXD passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE -> START on a synchronized 1->0 edge.
  - START: samples the line at DIV/2 (floor) CE cycles. If the sample is high, it is a false start and the FSM returns to IDLE. If low, the FSM samples every subsequent bit at DIV-cycle intervals, at mid-bit.
  - DATA bits shift into the shift register LSB first. PARITY is compared against the computed value. Only the first STOP bit is checked; the second stop bit is not sampled.
  - On the first-stop sample:
    - If RX_VALID=0: RX_DATA <= byte, RX_VALID=1, RX_PER and RX_FER updated.
    - If RX_VALID=1: the byte and its errors are discarded and RX_OVR is set.
    - If the stop bit was low, the FSM goes to WAIT_HIGH. Otherwise it goes to IDLE, and can detect a new start edge from the next cycle.
  - WAIT_HIGH: remains until the synchronized line reads 1, then -> IDLE. This prevents break re-triggering.
  - RX_ACK (on a CE cycle) clears RX_VALID, RX_PER, RX_FER and RX_OVR.
  - If RX_ACK coincides with frame completion, the new frame wins: RX_VALID stays 1 with the new data, and RX_OVR is not set.

## Timing
- Reset values: SER_TXD=1, TX_READY=1, TX_BUSY=0, RX_DATA=0, RX_VALID=0, RX_PER=0, RX_FER=0, RX_OVR=0. Both FSMs go to idle.
- RST_N asserted mid-frame aborts immediately. SER_TXD returns to 1 asynchronously and the partial RX byte is dropped.
- TX latency: accept-edge to SER_TXD falling edge is 1 CE cycle when the shifter is idle.
- Frame length = DIV × (1 + (CHR?7:8) + PE + (STOP?2:1)) CE cycles.
- RX latency: synchronized falling edge to RX_VALID rise = DIV/2 + DIV × (data bits + PE + 1) CE cycles, plus 2 cycles of synchronizer delay.
- TX_BUSY falls on the CE cycle after the last stop bit period ends, unless a back-to-back load occurs.

## Structure
- Shared CPU_PKG additions:
  - SCI_FRAME_CFG_t struct {CHR, PE, OE, STOP}.
  - Constants SCI_IDLE_LEVEL=1 and SCI_DIV_MIN=2.
  - enum SCI_RX_STATE_t.
- Sub-module sci_uart_peer_rx contains the synchronizer, RX FSM and error flags.
- TX logic stays in the top level.

## Test plan
- 8N1 with DIV=16: send 0xA5. Required: SER_TXD = 0,1,0,1,0,0,1,0,1,1, each bit held 16 CE cycles. Loop back to SER_RXD: RX_DATA=0xA5, RX_VALID=1, no error flags.
- 7O2 with DIV=4: send 0x53. Required: 7 data bits, parity bit 1, two stop bits. RX side: RX_DATA=0x53, RX_PER=0.
- 8E1: inject a frame 0x0F with parity bit 1 -> RX_PER=1. Inject a frame with stop bit 0 -> RX_FER=1; a new start is only detected after the line returns high.
- Two frames received without RX_ACK: RX_DATA stays at the first byte and RX_OVR=1. Then RX_ACK -> all flags are 0.
- Glitch: SER_RXD low for DIV/4 cycles -> false start, no RX_VALID. Back-to-back TX: a second byte written while TX_BUSY -> no idle bit between the frames.
- RST_N asserted during TX bit 3 -> SER_TXD=1 immediately; after release TX_READY=1 and TX_BUSY=0.
